// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle used both by requesters (toward the arbiter)
// and by the arbiter itself (toward memory).
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  req_rdwr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  data_acc_sz;
    logic                  we;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  data_ready;

    modport master (
        output req_rdwr, addr, data_acc_sz, we, write_data,
        input  read_data, data_ready
    );

    modport slave (
        input  req_rdwr, addr, data_acc_sz, we, write_data,
        output read_data, data_ready
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one memory port between the core (p0) and an
// auxiliary requester (p1), with a completion watchdog.
module mem_bus_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 1,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   p0,
    mem_bus_arbiter_if.slave   p1,
    mem_bus_arbiter_if.master  mem,
    output logic               grant_owner,
    output logic               busy,
    output logic               timeout_err
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic ACC_SZ_8 = 1'b0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic               last;
    logic [CNT_W-1:0]   cnt;

    logic               pick_c;
    logic               complete_c;
    logic               expire_c;
    logic               finish_c;
    logic [DATA_WIDTH-1:0] rdata_c;

    // Arbitration choice and end-of-transaction detection
    always_comb begin
        pick_c = p1.req_rdwr;
        if (p0.req_rdwr && p1.req_rdwr) begin
            pick_c = (FIXED_PRIORITY != 0) ? 1'b0 : ~last;
        end
        complete_c = (state == GRANT) && mem.data_ready;
        expire_c   = (state == GRANT) && (TIMEOUT_CYCLES != 0) &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES));
        finish_c   = complete_c || expire_c;
        rdata_c    = complete_c ? mem.read_data : '0;
    end

    // Memory-side mux and owner-side completion routing; reset blocks forwarding
    always_comb begin
        mem.req_rdwr    = 1'b0;
        mem.addr        = ADDR_ZERO;
        mem.data_acc_sz = ACC_SZ_8;
        mem.we          = 1'b0;
        mem.write_data  = '0;
        p0.read_data    = '0;
        p0.data_ready   = 1'b0;
        p1.read_data    = '0;
        p1.data_ready   = 1'b0;
        timeout_err     = 1'b0;

        if (state == GRANT) begin
            mem.req_rdwr = 1'b1;
            if (grant_owner) begin
                mem.addr        = p1.addr;
                mem.data_acc_sz = p1.data_acc_sz;
                mem.we          = p1.we;
                mem.write_data  = p1.write_data;
            end else begin
                mem.addr        = p0.addr;
                mem.data_acc_sz = p0.data_acc_sz;
                mem.we          = p0.we;
                mem.write_data  = p0.write_data;
            end
        end

        if (finish_c && !reset) begin
            timeout_err = ~complete_c;
            if (grant_owner) begin
                p1.data_ready = 1'b1;
                p1.read_data  = rdata_c;
            end else begin
                p0.data_ready = 1'b1;
                p0.read_data  = rdata_c;
            end
        end
    end

    // Grant FSM, owner/pointer registers and watchdog counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_owner <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0.req_rdwr || p1.req_rdwr) begin
                        state       <= GRANT;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        grant_owner <= pick_c;
                        last        <= pick_c;
                    end
                end
                GRANT: begin
                    if (finish_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule
